// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined unsigned multiplier returning the low XLEN bits of mcand*mplier
//
// Purpose: fully pipelined multiplier. Each stage consumes CHUNK bits of the
// multiplier and accumulates one CHUNK x XLEN partial product. One operation
// is accepted per cycle. Each result appears NUM_STAGES cycles after its start,
// together with a one-cycle done pulse.
//
// Ports:
//   clock   in   1     rising-edge clock
//   reset   in   1     asynchronous reset, active low
//   start   in   1     launch a multiply using mcand/mplier sampled this edge
//   mcand   in   XLEN  multiplicand, unsigned
//   mplier  in   XLEN  multiplier, unsigned
//   product out  XLEN  (mcand*mplier) mod 2^XLEN, valid while done=1
//   done    out  1     one-cycle pulse per completed operation (registered)
module mult_pipe #(
  parameter int XLEN       = 64,
  parameter int NUM_STAGES = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] mplier,
  output logic [XLEN-1:0] product,
  output logic            done
);

  localparam int CHUNK = XLEN / NUM_STAGES;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic            valid_d,   valid_q;
    logic [XLEN-1:0] partial_d, partial_q;
    logic [XLEN-1:0] mcand_d,   mcand_q;
    logic [XLEN-1:0] mplier_d,  mplier_q;

    // Inputs to this stage: stage 0 takes the ports, the others take the
    // registers of the stage before. Stage 0 starts from a zero partial sum.
    logic            in_valid;
    logic [XLEN-1:0] in_partial;
    logic [XLEN-1:0] in_mcand;
    logic [XLEN-1:0] in_mplier;

    if (s == 0) begin : g_first
      assign in_valid   = start;
      assign in_partial = '0;
      assign in_mcand   = mcand;
      assign in_mplier  = mplier;
    end else begin : g_rest
      assign in_valid   = g_stage[s-1].valid_q;
      assign in_partial = g_stage[s-1].partial_q;
      assign in_mcand   = g_stage[s-1].mcand_q;
      assign in_mplier  = g_stage[s-1].mplier_q;
    end

    // Data registers load only behind a valid input. That keeps idle stages
    // quiet and holds each result steady until the next operation arrives.
    always_comb begin
      valid_d   = in_valid;
      partial_d = partial_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      if (in_valid) begin
        partial_d = in_partial + in_mcand * XLEN'(in_mplier[CHUNK-1:0]);
        mcand_d   = in_mcand << CHUNK;
        mplier_d  = in_mplier >> CHUNK;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q   <= 1'b0;
        partial_q <= '0;
        mcand_q   <= '0;
        mplier_q  <= '0;
      end else begin
        valid_q   <= valid_d;
        partial_q <= partial_d;
        mcand_q   <= mcand_d;
        mplier_q  <= mplier_d;
      end
    end
  end

  assign product = g_stage[NUM_STAGES-1].partial_q;
  assign done    = g_stage[NUM_STAGES-1].valid_q;

endmodule
